// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, BITS_PER_CYCLE multiplier bits per clock.
// Optional running accumulation of the previous result is enabled by defining SEQ_MULT_ACC_EN.
module seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
`ifdef SEQ_MULT_ACC_EN
    input  logic                 in_acc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [1:0]           dbg_state_o
);

    localparam int PW  = 2 * WIDTH;
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = WIDTH / BPC;
    localparam int CW  = $clog2(N + 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("seq_multiplier: WIDTH must be >= 2");
    end
    if ((BPC < 1) || (WIDTH % BPC != 0)) begin : g_bad_bpc
        $error("seq_multiplier: BITS_PER_CYCLE must divide WIDTH");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid/data are held by the source until that edge, ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            signed_q, signed_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic [PW-1:0]   base;
    logic [BPC-1:0]  chunk;
    logic            last;
    logic [PW-1:0]   term;
    logic [PW-1:0]   corr;

`ifdef SEQ_MULT_ACC_EN
    logic [PW-1:0]   prev_q, prev_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= prev_d;
    end

    assign base = in_acc ? prev_q : '0;
`else
    assign base = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    // a_sh_q is the sign/zero-extended multiplicand pre-shifted to the current chunk's weight.
    // In signed mode the top chunk's MSB carries weight -2^(BPC-1), hence the correction term.
    assign chunk = b_q[BPC-1:0];
    assign last  = (cnt_q == CW'(N - 1));
    assign term  = a_sh_q * PW'(chunk);
    assign corr  = (signed_q && last && chunk[BPC-1]) ? (a_sh_q << BPC) : '0;

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_d       = b_q;
        signed_d  = signed_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SEQ_MULT_ACC_EN
        prev_d    = prev_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d   = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
                    b_d      = in_b;
                    signed_d = in_signed;
                    cnt_d    = '0;
                    p_d      = base;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                p_d    = p_q + term - corr;
                a_sh_d = a_sh_q << BPC;
                b_d    = b_q >> BPC;
                cnt_d  = cnt_q + CW'(1);
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
`ifdef SEQ_MULT_ACC_EN
                    prev_d  = p_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_p       = (state_q == DONE) ? p_q : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: three instances (BITS_PER_CYCLE 1, 2, 4) at WIDTH=8, directed cases
// plus random operands against an arithmetic reference; SEQ_MULT_ACC_EN adds accumulate cases.
module tb_seq_multiplier;

`ifdef SEQ_MULT_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       in_valid = '0;
    logic [2:0]       in_signed = '0;
    logic [2:0]       in_acc = '0;
    logic [2:0]       out_ready = '0;
    logic [7:0]       in_a [3];
    logic [7:0]       in_b [3];
    wire  [2:0]       in_ready;
    wire  [2:0]       out_valid;
    wire  [2:0][15:0] out_p;
    wire  [2:0][1:0]  dbg_state;

    logic [15:0] exp_q [$];
    logic [15:0] prev [3];
    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(BPC)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_a       (in_a[g]),
            .in_b       (in_b[g]),
            .in_signed  (in_signed[g]),
`ifdef SEQ_MULT_ACC_EN
            .in_acc     (in_acc[g]),
`endif
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_p      (out_p[g]),
            .dbg_state_o(dbg_state[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 2);
    endfunction

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x;
        int y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge after the accept edge.
    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic acc);
        in_a[k]      = a;
        in_b[k]      = b;
        in_signed[k] = s;
        in_acc[k]    = acc;
        in_valid[k]  = 1'b1;
        check("in_ready_idle", 16'(in_ready[k]), 16'h1);
        exp_q.push_back(model(a, b, s) + ((ACC_EN && acc) ? prev[k] : 16'h0));
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    // Waits for out_valid while scrambling ignored inputs, checks latency and product.
    task automatic wait_done(input int k, output logic [15:0] exp);
        int lat = 0;
        while (!out_valid[k] && lat < 40) begin
            out_ready[k] = 1'($urandom_range(0, 1));
            in_valid[k]  = 1'($urandom_range(0, 1));
            in_a[k]      = 8'($urandom);
            in_b[k]      = 8'($urandom);
            in_signed[k] = 1'($urandom_range(0, 1));
            in_acc[k]    = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        check("latency", 16'(lat), 16'(lat_of(k)));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("out_p", out_p[k], exp);
    endtask

    task automatic release_out(input int k, input logic [15:0] exp);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        check("out_valid_drop", 16'(out_valid[k]), 16'h0);
        check("in_ready_back", 16'(in_ready[k]), 16'h1);
        prev[k] = exp;
    endtask

    task automatic txn(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic acc);
        logic [15:0] e;
        send(k, a, b, s, acc);
        wait_done(k, e);
        release_out(k, e);
    endtask

    initial begin
        logic [15:0] e;
        logic [7:0]  na;
        logic [7:0]  nb;
        for (int k = 0; k < 3; k++) begin
            in_a[k] = '0;
            in_b[k] = '0;
            prev[k] = '0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 16'(in_ready[k]), 16'h1);
            check("rst_out_valid", 16'(out_valid[k]), 16'h0);
            check("rst_out_p", out_p[k], 16'h0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner operands on the one-bit-per-cycle instance.
        send(0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        wait_done(0, e);
        check("ff_x_ff", out_p[0], 16'hFE01);
        release_out(0, e);
        txn(0, 8'h80, 8'h80, 1'b1, 1'b0);
        txn(0, 8'hFF, 8'h01, 1'b1, 1'b0);
        txn(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        txn(0, 8'h00, 8'hA5, 1'b1, 1'b0);
        txn(0, 8'h7F, 8'h80, 1'b1, 1'b0);

        // Result held in DONE while a new pair waits; it is taken one cycle after release.
        send(0, 8'd13, 8'd11, 1'b0, 1'b0);
        wait_done(0, e);
        na = 8'h00;
        nb = 8'h00;
        for (int i = 0; i < 5; i++) begin
            na = 8'($urandom);
            nb = 8'($urandom);
            in_a[0]      = na;
            in_b[0]      = nb;
            in_signed[0] = 1'b0;
            in_acc[0]    = 1'b0;
            in_valid[0]  = 1'b1;
            @(negedge clk);
            check("hold_out_valid", 16'(out_valid[0]), 16'h1);
            check("hold_in_ready", 16'(in_ready[0]), 16'h0);
            check("hold_out_p", out_p[0], e);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("hold_rel_valid", 16'(out_valid[0]), 16'h0);
        check("hold_rel_ready", 16'(in_ready[0]), 16'h1);
        prev[0] = e;
        exp_q.push_back(model(na, nb, 1'b0));
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("hold_accepted", 16'(in_ready[0]), 16'h0);
        wait_done(0, e);
        release_out(0, e);

        // Reset in the middle of BUSY abandons the transaction.
        send(0, 8'd200, 8'd100, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 16'(out_valid[0]), 16'h0);
        check("midrst_out_p", out_p[0], 16'h0);
        check("midrst_in_ready", 16'(in_ready[0]), 16'h1);
        void'(exp_q.pop_back());
        for (int k = 0; k < 3; k++) prev[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_no_stale", 16'(out_valid[0]), 16'h0);
        end
        send(0, 8'd7, 8'd6, 1'b0, 1'b0);
        wait_done(0, e);
        check("seven_x_six", out_p[0], 16'd42);
        release_out(0, e);

`ifdef SEQ_MULT_ACC_EN
        txn(0, 8'd100, 8'd100, 1'b0, 1'b0);
        check("acc_step1", prev[0], 16'd10000);
        txn(0, 8'd200, 8'd200, 1'b0, 1'b1);
        check("acc_step2", prev[0], 16'd50000);
        txn(0, 8'd255, 8'd255, 1'b0, 1'b1);
        check("acc_step3", prev[0], 16'd49489);
`endif

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                txn(k, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
